alu_mult_sequencer: RTL and testbench

Multi-cycle unsigned 32x32→64 shift-add multiplier controller that acts as the initiator of the 32-bit ALU operand interface. It owns a 65-bit accumulate/shift datapath and issues one ALU add per cycle. It drives `alu_a`, `alu_b` and `alu_op`, and consumes `alu_result` and `alu_carry_out` from an external ALU instance. It sits beside the ALU in the datapath and gives the core a start/busy/done multiply service without a dedicated adder.

---
 rtl/alu_mult_sequencer_if.sv | 20 ++
 rtl/alu_mult_sequencer.sv | 98 +++++++++
 tb/tb_alu_mult_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mult_sequencer_if.sv
// Operand bus between the multiply sequencer (master) and the shared 32-bit ALU (slave).
interface alu_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry_out;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry_out
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry_out
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Unsigned 32x32->64 shift-add multiplier that borrows an external ALU for one add per cycle.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the iteration loop and finish at once.
module alu_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  alu_mult_sequencer_if.master   alu
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic             lastIter;

  assign lastIter = (count == CW'(WIDTH - 1));
  assign product  = {hi, lo};

  // op[2] is held low so the ALU carry-in is zero; only RUN presents live operands.
  always_comb begin
    alu.alu_op = OP_ADD;
    alu.alu_a  = '0;
    alu.alu_b  = '0;
    if (state == RUN) begin
      alu.alu_a = hi;
      alu.alu_b = lo[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (multiplicand == '0 || multiplier == '0) begin
              lo    <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end
        end
        RUN: begin
          // 65-bit {carry, sum, lo} shifted right by one; the carry becomes hi's MSB.
          hi    <= {alu.alu_carry_out, alu.alu_result[WIDTH-1:1]};
          lo    <= {alu.alu_result[0], lo[WIDTH-1:1]};
          count <= count + 1'b1;
          if (lastIter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer with a behavioural ALU and a product scoreboard.
module tb_alu_mult_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mcandIn = '0;
  logic [31:0] mplierIn = '0;
  logic        busy, done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;
  logic [63:0] expQ[$];

  alu_mult_sequencer_if #(.WIDTH(32)) aluBus ();

  // Combinational ALU: add with carry-in taken from op[2].
  assign {aluBus.alu_carry_out, aluBus.alu_result} =
    {1'b0, aluBus.alu_a} + {1'b0, aluBus.alu_b} + {32'b0, aluBus.alu_op[2]};

  alu_mult_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(mcandIn), .multiplier(mplierIn),
    .busy(busy), .done(done), .product(product), .alu(aluBus.master)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mcandIn = a;
    mplierIn = b;
    start = 1'b1;
    expQ.push_back({32'b0, a} * {32'b0, b});
  endtask

  // Counts negedges after the accept edge until done; optionally injects a start at cycle injectAt.
  task automatic wait_done(input bit keepStart, input int injectAt,
                           output int n, output int busyCnt, output bit overlap);
    n = 0; busyCnt = 0; overlap = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && !keepStart) begin
        start = 1'b0;
        mcandIn = $urandom;
        mplierIn = $urandom;
      end
      if (n == injectAt) begin start = 1'b1; mcandIn = 32'd2; mplierIn = 32'd2; end
      if (n == injectAt + 1) start = 1'b0;
      if (busy) busyCnt++;
      if (busy && done) overlap = 1'b1;
    end while (!done && n < 200);
  endtask

  task automatic pop_check(input string name);
    logic [63:0] exp;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL %s: done seen with empty scoreboard, product=%h", name, product);
    end else begin
      exp = expQ.pop_front();
      if (product !== exp) begin
        errors++;
        $display("FAIL %s: product=%h expected=%h", name, product, exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    checks++;
    if (aluBus.alu_a !== 32'd0 || aluBus.alu_b !== 32'd0 || aluBus.alu_op !== 3'b010) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h op=%b expected 0 0 010",
               aluBus.alu_a, aluBus.alu_b, aluBus.alu_op);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n, bc; bit ov;
    launch(32'd3, 32'd5);
    wait_done(1'b0, -5, n, bc, ov);
    checks++;
    if (n !== 33 || bc !== 32 || ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_timing: doneAt=%0d busyCycles=%0d overlap=%b expected 33 32 0", n, bc, ov);
    end
    pop_check("basic_product");
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 64'h0000_0000_0000_000F || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: product=%h busy=%b done=%b expected f 0 0", product, busy, done);
    end
  endtask

  task automatic test_max();
    int n, bc; bit ov;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, -5, n, bc, ov);
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_product: product=%h expected fffffffe00000001", product);
    end
    pop_check("max_scoreboard");
  endtask

  task automatic test_start_while_busy();
    int n, bc, extra; bit ov;
    launch(32'd7, 32'd9);
    wait_done(1'b0, 11, n, bc, ov);
    checks++;
    if (n !== 33 || product !== 64'h3F) begin
      errors++;
      $display("FAIL busy_start: doneAt=%0d product=%h expected 33 3f", n, product);
    end
    pop_check("busy_start_scoreboard");
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_once: extraActiveCycles=%0d expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int n, bc; bit ov;
    launch(32'd100, 32'd100);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    checks++;
    if ({busy, done} !== 2'b00 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    launch(32'd2, 32'd3);
    wait_done(1'b0, -5, n, bc, ov);
    checks++;
    if (n !== 33 || product !== 64'd6) begin
      errors++;
      $display("FAIL reset_mid_after: doneAt=%0d product=%h expected 33 6", n, product);
    end
    pop_check("reset_mid_scoreboard");
  endtask

  task automatic test_zero();
    int n, bc; bit ov;
    launch(32'd0, 32'd1234);
    wait_done(1'b0, -5, n, bc, ov);
`ifdef MULT_ZERO_BYPASS_EN
    checks++;
    if (n !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL zero_bypass: doneAt=%0d busyCycles=%0d expected 1 0", n, bc);
    end
`else
    checks++;
    if (n !== 33 || bc !== 32) begin
      errors++;
      $display("FAIL zero_full: doneAt=%0d busyCycles=%0d expected 33 32", n, bc);
    end
`endif
    pop_check("zero_product");
  endtask

  task automatic test_back_to_back();
    int n, bc, gap; bit ov;
    launch(32'h8000_0000, 32'd2);
    expQ.push_back(64'h1_0000_0000);
    expQ.push_back(64'h1_0000_0000);
    wait_done(1'b1, -5, n, bc, ov);
    checks++;
    if (n !== 33 || ov !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: doneAt=%0d overlap=%b expected 33 0", n, ov);
    end
    pop_check("b2b_product0");
    for (int k = 1; k < 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 100);
      if (k == 2) start = 1'b0;
      checks++;
      if (gap !== 34) begin
        errors++;
        $display("FAIL b2b_gap%0d: gap=%0d expected 34", k, gap);
      end
      pop_check("b2b_product");
    end
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || expQ.size() !== 0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b pending=%0d expected 0 0", busy, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_start_while_busy();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
